// File: rtl/sysid_verify.sv
// Reads the sysid slave's ID and timestamp words over Avalon-MM and compares
// them against the expected build values, reporting pass/fail and read timeouts.
module sysid_verify #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1555990627,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter logic        AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD_ID = 2'd1;
  localparam logic [1:0] RD_TS = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  logic [1:0]  state_q,       state_d;
  logic        avm_read_q,    avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic [15:0] wait_cnt_q,    wait_cnt_d;
  logic        auto_pend_q,   auto_pend_d;
  logic        done_q,        done_d;
  logic        id_ok_q,       id_ok_d;
  logic        ts_ok_q,       ts_ok_d;
  logic        pass_q,        pass_d;
  logic        timeout_q,     timeout_d;
  logic [31:0] id_word_q,     id_word_d;
  logic [31:0] ts_word_q,     ts_word_d;
  logic        wait_last;

  // 17-bit compare so TIMEOUT_CYCLES = 65535 cannot wrap the counter
  assign wait_last = (({1'b0, wait_cnt_q} + 17'd1) == {1'b0, TIMEOUT_CYCLES});

  always_comb begin
    state_d       = state_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    wait_cnt_d    = wait_cnt_q;
    auto_pend_d   = auto_pend_q;
    done_d        = 1'b0;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    id_word_d     = id_word_q;
    ts_word_d     = ts_word_q;

    case (state_q)
      IDLE: begin
        if (start || auto_pend_q) begin
          state_d       = RD_ID;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          wait_cnt_d    = '0;
          auto_pend_d   = 1'b0;
        end
      end
      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          wait_cnt_d = '0;
          if (state_q == RD_ID) begin
            id_word_d     = avm_readdata;
            state_d       = RD_TS;
            avm_address_d = 1'b1;
          end else begin
            ts_word_d     = avm_readdata;
            state_d       = CHECK;
            avm_read_d    = 1'b0;
            avm_address_d = 1'b0;
          end
        end else if (wait_last) begin
          state_d       = IDLE;
          avm_read_d    = 1'b0;
          avm_address_d = 1'b0;
          wait_cnt_d    = '0;
          done_d        = 1'b1;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          pass_d        = 1'b0;
          timeout_d     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      CHECK: begin
        id_ok_d   = (id_word_q == EXPECTED_ID);
        ts_ok_d   = (ts_word_q == EXPECTED_TS);
        timeout_d = 1'b0;
        pass_d    = (id_word_q == EXPECTED_ID) && (ts_word_q == EXPECTED_TS);
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      wait_cnt_q    <= '0;
      auto_pend_q   <= AUTO_START;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      id_word_q     <= '0;
      ts_word_q     <= '0;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      wait_cnt_q    <= wait_cnt_d;
      auto_pend_q   <= auto_pend_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      id_word_q     <= id_word_d;
      ts_word_q     <= ts_word_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign id_word     = id_word_q;
  assign ts_word     = ts_word_q;

endmodule
